// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage configuration: machine widths, reset pc and fetch FSM encodings.
package if_fetch_unit_pkg;

  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_WAIT  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_t;

  // Any state other than IDLE holds one buffer credit for its request.
  function automatic logic if_busy(input if_state_t s);
    return s != IF_IDLE;
  endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Circular FIFO with wrap-bit pointers; head is read combinationally, flush resets the pointers.
// A push while full is legal only together with a pop; the caller's credit scheme guarantees that.
module if_inst_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[IDX_W-1:0]];

  // Storage is reset so the decode-facing fields read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[IDX_W-1:0]] <= push_data;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding icache request, pc accepted 1 cycle before request, decode valid 3 cycles after accept.
// stall_o holds the PC register whenever the FSM is busy or buffer credits run out; flush drops buffered and in-flight work.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = XLEN,
  parameter int INST_W    = INST_LEN,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              ic_req_valid_o,
  output logic [ADDR_W-1:0] ic_req_addr_o,
  input  logic              ic_req_ready_i,
  input  logic              ic_resp_valid_i,
  input  logic [INST_W-1:0] ic_resp_data_i,
  input  logic              ic_resp_err_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_err_o,
  input  logic              id_ready_i
);

  localparam int PTR_W = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } fetch_entry_t;

  if_state_t         state;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  buf_count;
  logic [PTR_W-1:0]  used;
  logic              buf_full;
  logic              buf_empty;
  logic              can_take;
  logic              accept;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // A response arriving in WAIT frees the FSM's credit, so a new pc can be taken that cycle.
  assign used     = buf_count + PTR_W'(if_busy(state));
  assign can_take = (state == IF_IDLE) || (state == IF_WAIT && ic_resp_valid_i);
  assign stall_o  = ~can_take | buf_full | (used >= PTR_W'(BUF_DEPTH));
  assign accept   = pc_valid_i & ~stall_o & ~flush_i;
  assign push     = (state == IF_WAIT) & ic_resp_valid_i & ~flush_i;
  assign pop      = id_valid_o & id_ready_i;

  assign push_entry = '{pc: req_pc, inst: ic_resp_data_i, err: ic_resp_err_i};

  assign ic_req_valid_o = (state == IF_REQ);
  assign ic_req_addr_o  = req_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IF_IDLE;
      req_pc <= '0;
    end else begin
      if (accept) req_pc <= pc_i;
      case (state)
        IF_IDLE: if (accept) state <= IF_REQ;
        IF_REQ: begin
          // An unaccepted request may be withdrawn; an accepted one still owes a response.
          if (flush_i)             state <= ic_req_ready_i ? IF_DRAIN : IF_IDLE;
          else if (ic_req_ready_i) state <= IF_WAIT;
        end
        IF_WAIT: begin
          if (ic_resp_valid_i) state <= accept ? IF_REQ : IF_IDLE;
          else if (flush_i)    state <= IF_DRAIN;
        end
        IF_DRAIN: if (ic_resp_valid_i) state <= IF_IDLE;
        default:  state <= IF_IDLE;
      endcase
    end
  end

  if_inst_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign id_valid_o = ~buf_empty;
  assign id_pc_o    = head_entry.pc;
  assign id_inst_o  = head_entry.inst;
  assign id_err_o   = head_entry.err;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that sits directly downstream of the PC register. It accepts fetch addresses from the PC register and issues them to the icache over a valid/ready request channel. It collects responses into a 2-entry instruction buffer and presents {pc, inst, err} to decode with a valid/ready handshake. It back-pressures the PC register through `stall_o`, and discards in-flight work on a redirect (`flush_i`).

## Interface
Parameters:
- `ADDR_W`, default 64: fetch address width (`XLEN`).
- `INST_W`, default 32: instruction width (`INST_LEN`).
- `BUF_DEPTH`, default 2: instruction buffer entries. Power of two, ≥2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pc_i`  in  ADDR_W: next fetch address from the PC register.
- `pc_valid_i`  in  1: fetch address valid (PC register read request).
- `stall_o`  out  1: unit cannot accept `pc_i` this cycle. PC register holds its value.
- `flush_i`  in  1: redirect from branch/trap. Kills buffered and in-flight fetches.
- `ic_req_valid_o`  out  1: icache request valid.
- `ic_req_addr_o`  out  ADDR_W: icache request address.
- `ic_req_ready_i`  in  1: icache accepts the request.
- `ic_resp_valid_i`  in  1: icache response valid (single-cycle pulse).
- `ic_resp_data_i`  in  INST_W: fetched instruction.
- `ic_resp_err_i`  in  1: access fault on the fetch.
- `id_valid_o`  out  1: decode output valid.
- `id_pc_o`  out  ADDR_W: pc of the presented instruction.
- `id_inst_o`  out  INST_W: presented instruction.
- `id_err_o`  out  1: access fault flag for the presented instruction.
- `id_ready_i`  in  1: decode consumes the entry.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: `ic_req_valid_o`=1, address held in `req_pc`.
  - WAIT: request accepted, response pending.
  - DRAIN: request accepted before a flush; response must be discarded.
- Credit: `used = buf_count + (state∈{REQ,WAIT,DRAIN})`. A pc is accepted only when `used < BUF_DEPTH`.
- `stall_o = ~(state==IDLE || (state==WAIT && ic_resp_valid_i)) | (used_next_full)`. It is 1 whenever a `pc_i` presented this cycle would not be latched. `flush_i` does not raise `stall_o`.
- Accept: `pc_valid_i & ~stall_o & ~flush_i` → `req_pc <= pc_i`, next state REQ.
- REQ and `ic_req_ready_i` → WAIT. The address must stay stable while in REQ.
- WAIT and `ic_resp_valid_i` → push {`req_pc`, data, err} to the buffer. Next state is REQ if a new pc was accepted in the same cycle, else IDLE.
- DRAIN and `ic_resp_valid_i` → response dropped, → IDLE. No pc is accepted while in DRAIN.
- Flush, applied at the same edge in every case:
  - Buffer emptied (pointers reset).
  - REQ with ready=1 → DRAIN. REQ with ready=0 → IDLE; the request is withdrawn, which the icache protocol permits.
  - WAIT → DRAIN, unless `ic_resp_valid_i` is high the same cycle, in which case the response is dropped → IDLE.
  - IDLE/DRAIN unchanged.
- Buffer: a circular FIFO with wrap-bit pointers (`$clog2(BUF_DEPTH)+1` bits).
  - Full = pointers equal except the MSB. Empty = pointers equal.
  - Pop on `id_valid_o & id_ready_i`. Push and pop in the same cycle are allowed when full, because the credit rule guarantees the push only happens if the slot was reserved.
- Decode outputs are driven straight from the head entry. `id_valid_o = ~empty`.
- Error responses are buffered like normal instructions; this unit raises no trap.

## Timing
- Reset values:
  - state IDLE, buffer empty.
  - `ic_req_valid_o`=0, `id_valid_o`=0, `stall_o`=0.
  - `ic_req_addr_o`, `id_pc_o`, `id_inst_o` = 0. `id_err_o`=0.
- Latency with zero-wait icache (ready=1, response the cycle after acceptance):
  - cycle 0: pc accepted.
  - cycle 1: `ic_req_valid_o`.
  - cycle 2: response.
  - cycle 3: `id_valid_o`.
- Throughput: one fetch per 2 cycles (one outstanding request).
- Flush in cycle N: `id_valid_o`=0 in N+1. A pc presented in N+1 is accepted unless the state is DRAIN.
- Reset mid-operation: everything returns asynchronously to reset values. A late icache response after reset is ignored (IDLE).

## Structure
- Shared package/header (`sysconfig.v`): `XLEN`, `INST_LEN`, `PC_RESET_ADDR`, and FSM state encodings `IF_IDLE`/`IF_REQ`/`IF_WAIT`/`IF_DRAIN` (2-bit).
- Sub-module `if_inst_fifo`: a parameterised synchronous FIFO holding {pc, inst, err}, with flush-clear, count, full and empty outputs.

## Test plan
- Basic fetch: pc 0x8000_0000 valid, ready=1, response 0x0000_0013 one cycle later → `id_valid_o` 3 cycles after accept with pc 0x8000_0000 and inst 0x13.
- Back-pressure: `id_ready_i`=0, fetch 0x80000000/0x80000004/0x80000008 → two buffered, `stall_o`=1 holds 0x80000008 until a pop; order is preserved.
- Icache wait: `ic_req_ready_i` low for 3 cycles → `ic_req_addr_o` is stable in every one, then exactly one response is pushed.
- Flush in WAIT: flush while 0x80000010 is outstanding, response arrives 2 cycles later → dropped (DRAIN), `id_valid_o` stays 0. The next pc 0x80000100 is fetched after IDLE.
- Flush with simultaneous response: flush and `ic_resp_valid_i` in the same cycle → response dropped, state IDLE the next cycle, buffer empty.
- Async reset during REQ: `rst` pulse → `ic_req_valid_o`=0 immediately. A stray response is ignored and `id_valid_o`=0.
